zrb_at_responder: RTL and testbench
===================================

Name: zrb_at_responder

Overview:
- Slave-side model of the JY-MCU/HC-06 AT command interface; it is the module-side counterpart of zrb_bt_controller.
- Consumes UART bytes from an RX zrb_sync_fifo (first-word-fall-through), frames commands by inter-byte gap timeout, validates "AT" and "AT+BAUDn", and pushes the module's reply into a TX zrb_sync_fifo.
- Exposes the selected baud code so a zrb_baud_generator pair can be switched after the reply has been sent.
- Used in loopback builds and as the synthesizable peer in controller regression.

Parameters:
- GAP_TICKS, 16, number of tick pulses without a new byte that terminates a command (1..255).
- BAUD_INIT, 4, baud code after reset (4 = 9600).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  timeout time-base enable (a baud_clk_rx_en-class strobe)
- rx_data  in  8  head byte of RX FIFO; valid when rx_empty=0
- rx_empty  in  1  RX FIFO empty
- rx_rd  out  1  pop RX FIFO; combinational
- tx_full  in  1  TX FIFO full
- tx_wr  out  1  push TX FIFO; combinational
- tx_data  out  8  byte to push; valid with tx_wr
- baud_sel  out  4  current baud code, 1..8
- cmd_ok  out  1  one-cycle pulse when a valid command's reply has been fully queued
- cmd_err  out  1  one-cycle pulse when a framed command is rejected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous. On reset: state=IDLE, len=0, gap_cnt=0, idx=0, baud_sel=BAUD_INIT, cmd_ok=0, cmd_err=0, busy=0. rx_rd and tx_wr are 0 because the state is IDLE with no traffic. Reset mid-command or mid-reply discards the partial buffer and the unsent reply bytes; baud_sel returns to BAUD_INIT.
- States: IDLE, COLLECT, EVAL, SEND.
- rx_rd = (state==IDLE or COLLECT) & ~rx_empty & (len<8). A byte is consumed on the edge where rx_rd=1: buf[len]<=rx_data, len<=len+1, gap_cnt<=0. The block can pop one byte every cycle.
- IDLE: on consumption go to COLLECT. tick is ignored.
- COLLECT gap counting: on a cycle with tick=1 and no consumption, gap_cnt increments. When tick and consumption coincide, consumption wins and gap_cnt becomes 0.
- COLLECT exit: go to EVAL when gap_cnt reaches GAP_TICKS, or on the cycle after len becomes 8.
- EVAL (exactly 1 cycle) accepts only exact uppercase ASCII commands:
  - len==2 and buf="AT": reply "OK" (2 bytes), no baud change.
  - len==8, buf[0..6]="AT+BAUD", buf[7] in '1'..'8': reply "OK" followed by the rate string, and pend_baud=digit-'0'. Rate strings: 1:"1200", 2:"2400", 3:"4800", 4:"9600", 5:"19200", 6:"38400", 7:"57600", 8:"115200". The reply is at most 8 bytes.
  - Anything else, including lowercase, '0', '9', or a wrong length: cmd_err=1 for one cycle, then go to IDLE.
  - Every exit from EVAL clears len and gap_cnt.
- SEND: tx_wr = ~tx_full and tx_data = reply[idx]. idx increments on each write.
  - On the write of the last byte: idx<=0, cmd_ok=1 for one cycle, baud_sel<=pend_baud (BAUD commands only), go to IDLE.
  - baud_sel changes only after the whole reply has been queued.
  - While tx_full=1 the block stalls with no write and holds idx.
- No RX consumption happens in EVAL or SEND. Bytes that arrive then stay in the RX FIFO and start the next command.
- Worst-case latency from the last byte consumed (8-byte command) to the first tx_wr is 2 cycles: 1 cycle into EVAL, 1 cycle of EVAL.
- gap_cnt is 8 bits and saturates. len is 4 bits and never exceeds 8.

Test Plan:
- Bytes 0x41,0x54 on back-to-back cycles, then 16 ticks -> tx_wr pushes 0x4F,0x4B on consecutive cycles; cmd_ok pulses on the 0x4B cycle; baud_sel stays 4.
- "AT+BAUD8" back-to-back -> EVAL with no tick required; pushes "OK115200" (0x4F,0x4B,0x31,0x31,0x35,0x32,0x30,0x30); baud_sel becomes 8 only in the cycle after the last push.
- "AT+BAUD9" -> cmd_err pulse; no tx_wr; baud_sel unchanged. Repeat with "at" -> same result.
- "AT+BAUD4" with tx_full forced high for 5 cycles after the 3rd byte -> stall with idx held; remaining "600" resumes in order after tx_full drops; total "OK9600".
- "AT", then "AT" arrives in the RX FIFO during SEND -> rx_rd stays low until IDLE; the second command is answered "OK"; exactly two cmd_ok pulses.
- Assert reset mid-SEND after 3 bytes of a BAUD7 reply -> outputs return to reset values immediately; baud_sel=4; no further tx_wr.

Source files
------------

// File: rtl/zrb_at_responder.sv
// zrb_at_responder
// Module-side model of the HC-06 style AT command interface. It pops bytes from
// an RX FIFO and frames a command when the inter-byte gap times out or the
// buffer fills. It accepts exactly "AT" and "AT+BAUDn" (n = 1..8) and pushes
// the reply into a TX FIFO. A new baud code is only published once the whole
// reply has been queued, so the TX generator keeps the old rate while the
// reply is still draining.

module zrb_at_responder #(
    parameter int           GAP_TICKS = 16,
    parameter logic [3:0]   BAUD_INIT = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic [3:0] baud_sel,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL,
        SEND
    } state_t;

    localparam logic [8:0] GAP_LIMIT = 9'(GAP_TICKS);
    localparam logic [3:0] BUF_DEPTH = 4'd8;

    state_t     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [7:0] gap_q, gap_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] replyLen_q, replyLen_d;
    logic [3:0] pend_q, pend_d;
    logic       isBaud_q, isBaud_d;
    logic [3:0] baud_q, baud_d;
    logic [7:0] rxBuf_q [0:7];

    logic       consume;
    logic [8:0] gapNext;
    logic       atOk;
    logic       baudOk;
    logic [3:0] digit;
    logic       lastByte;

    // Length of the rate text that follows "OK" for a given baud code.
    function automatic logic [3:0] rateLen(input logic [3:0] code);
        logic [3:0] n;
        case (code)
            4'd1, 4'd2, 4'd3, 4'd4: n = 4'd4;
            4'd5, 4'd6, 4'd7:       n = 4'd5;
            4'd8:                   n = 4'd6;
            default:                n = 4'd0;
        endcase
        return n;
    endfunction

    // Rate text for a baud code, left-justified in six byte lanes.
    function automatic logic [47:0] rateStr(input logic [3:0] code);
        logic [47:0] s;
        case (code)
            4'd1:    s = {"1200", 16'h0000};
            4'd2:    s = {"2400", 16'h0000};
            4'd3:    s = {"4800", 16'h0000};
            4'd4:    s = {"9600", 16'h0000};
            4'd5:    s = {"19200", 8'h00};
            4'd6:    s = {"38400", 8'h00};
            4'd7:    s = {"57600", 8'h00};
            4'd8:    s = "115200";
            default: s = 48'h0;
        endcase
        return s;
    endfunction

    // Byte idx of the reply: "OK" first, then the rate text for BAUD commands.
    function automatic logic [7:0] replyByte(input logic [3:0] code, input logic [2:0] idx);
        logic [47:0] s;
        logic [2:0]  pos;
        logic [7:0]  b;
        s   = rateStr(code);
        pos = idx - 3'd2;
        case (idx)
            3'd0:    b = 8'h4F;
            3'd1:    b = 8'h4B;
            default: begin
                case (pos)
                    3'd0:    b = s[47:40];
                    3'd1:    b = s[39:32];
                    3'd2:    b = s[31:24];
                    3'd3:    b = s[23:16];
                    3'd4:    b = s[15:8];
                    3'd5:    b = s[7:0];
                    default: b = 8'h00;
                endcase
            end
        endcase
        return b;
    endfunction

    assign rx_rd    = ((state_q == IDLE) || (state_q == COLLECT)) && !rx_empty && (len_q < BUF_DEPTH);
    assign consume  = rx_rd;
    assign gapNext  = {1'b0, gap_q} + 9'd1;
    assign busy     = (state_q != IDLE);
    assign baud_sel = baud_q;

    assign atOk   = (len_q == 4'd2) && (rxBuf_q[0] == 8'h41) && (rxBuf_q[1] == 8'h54);
    assign baudOk = (len_q == 4'd8)
                 && (rxBuf_q[0] == 8'h41) && (rxBuf_q[1] == 8'h54) && (rxBuf_q[2] == 8'h2B)
                 && (rxBuf_q[3] == 8'h42) && (rxBuf_q[4] == 8'h41) && (rxBuf_q[5] == 8'h55)
                 && (rxBuf_q[6] == 8'h44)
                 && (rxBuf_q[7] >= 8'h31) && (rxBuf_q[7] <= 8'h38);
    assign digit    = rxBuf_q[7][3:0];
    assign lastByte = ({1'b0, idx_q} == (replyLen_q - 4'd1));

    // Next-state and output decode: framing, command check and reply streaming.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        replyLen_d = replyLen_q;
        pend_d     = pend_q;
        isBaud_d   = isBaud_q;
        baud_d     = baud_q;
        tx_wr      = 1'b0;
        tx_data    = 8'h00;
        cmd_ok     = 1'b0;
        cmd_err    = 1'b0;

        if (consume) begin
            len_d = len_q + 4'd1;
            gap_d = 8'h00;
        end

        case (state_q)
            IDLE: begin
                if (consume) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (len_q == BUF_DEPTH) begin
                    state_d = EVAL;
                end else if (!consume && tick) begin
                    gap_d = (gap_q == 8'hFF) ? gap_q : gapNext[7:0];
                    if (gapNext >= GAP_LIMIT) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                len_d = 4'd0;
                gap_d = 8'h00;
                idx_d = 3'd0;
                if (atOk) begin
                    replyLen_d = 4'd2;
                    isBaud_d   = 1'b0;
                    state_d    = SEND;
                end else if (baudOk) begin
                    replyLen_d = 4'd2 + rateLen(digit);
                    pend_d     = digit;
                    isBaud_d   = 1'b1;
                    state_d    = SEND;
                end else begin
                    cmd_err = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND: begin
                tx_data = replyByte(pend_q, idx_q);
                if (!tx_full) begin
                    tx_wr = 1'b1;
                    if (lastByte) begin
                        idx_d   = 3'd0;
                        cmd_ok  = 1'b1;
                        state_d = IDLE;
                        if (isBaud_q) begin
                            baud_d = pend_q;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset drops any partial command and unsent reply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 4'd0;
            gap_q      <= 8'h00;
            idx_q      <= 3'd0;
            replyLen_q <= 4'd0;
            pend_q     <= BAUD_INIT;
            isBaud_q   <= 1'b0;
            baud_q     <= BAUD_INIT;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            replyLen_q <= replyLen_d;
            pend_q     <= pend_d;
            isBaud_q   <= isBaud_d;
            baud_q     <= baud_d;
        end
    end

    // Command buffer: each popped byte lands at the current length position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rxBuf_q[i] <= 8'h00;
            end
        end else if (consume) begin
            rxBuf_q[len_q[2:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_zrb_at_responder.sv
// tb_zrb_at_responder
// Directed bench for zrb_at_responder. A small queue stands in for the RX FIFO,
// and every pushed TX byte is logged so whole replies can be compared with
// hand-written strings.

module tb_zrb_at_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_rd;
    logic       tx_full = 1'b0;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [3:0] baud_sel;
    logic       cmd_ok;
    logic       cmd_err;
    logic       busy;

    int passCount = 0;
    int checkCount = 0;

    logic [7:0] rxq[$];
    logic [7:0] txLog[$];
    int         okRxq[$];
    int         cyc = 0;
    int         lastPopEdge = 0;
    int         firstTxEdge = 0;
    bit         firstTxSeen = 0;
    int         prevTxCyc = 0;
    int         txGaps = 0;
    int         okCount = 0;
    int         errCount = 0;
    int         stallCnt = 0;
    int         rdDuringTx = 0;
    logic [7:0] okByte = 8'h00;
    logic [3:0] baudAtOk = 4'd0;
    bit         popReq = 0;
    bit         got;

    zrb_at_responder #(.GAP_TICKS(16), .BAUD_INIT(4'd4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .baud_sel (baud_sel),
        .cmd_ok   (cmd_ok),
        .cmd_err  (cmd_err),
        .busy     (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // RX FIFO model: pop on the edge where rx_rd was high, refresh the head after.
    always begin
        @(posedge clk);
        cyc++;
        if (popReq && rxq.size() > 0) begin
            void'(rxq.pop_front());
            lastPopEdge = cyc;
        end
        #2;
        rx_empty = (rxq.size() == 0);
        rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end

    // Mid-cycle observer: logs TX pushes and pulses, latches the RX pop request.
    always @(negedge clk) begin
        popReq = rx_rd;
        if (tx_wr) begin
            if (!firstTxSeen) begin
                firstTxSeen = 1;
                firstTxEdge = cyc;
            end else if (cyc != prevTxCyc + 1) begin
                txGaps++;
            end
            prevTxCyc = cyc;
            txLog.push_back(tx_data);
        end
        if (cmd_ok) begin
            okCount++;
            okByte   = tx_data;
            baudAtOk = baud_sel;
            okRxq.push_back(rxq.size());
        end
        if (cmd_err) errCount++;
        if (tx_full && busy && !tx_wr) stallCnt++;
        if (rx_rd && tx_wr) rdDuringTx++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkLog(input string tag, input string exp);
        checkOutput({tag, "_len"}, 32'(txLog.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (i < txLog.size()) begin
                checkOutput($sformatf("%s[%0d]", tag, i), 32'(txLog[i]), 32'(exp[i]));
            end
        end
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rxq.push_back(s[i]);
        end
    endtask

    task automatic clearLogs();
        txLog.delete();
        okRxq.delete();
        firstTxSeen = 0;
        txGaps      = 0;
        okCount     = 0;
        errCount    = 0;
        stallCnt    = 0;
        rdDuringTx  = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitTxCount(input int n, input string tag);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (txLog.size() >= n) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_wr", 32'(tx_wr), 32'd0);
        checkOutput("rst_rx_rd", 32'(rx_rd), 32'd0);
        checkOutput("rst_cmd_ok", 32'(cmd_ok), 32'd0);
        checkOutput("rst_cmd_err", 32'(cmd_err), 32'd0);
        checkOutput("rst_baud", 32'(baud_sel), 32'd4);
        reset = 1'b0;
        waitCycles(2);

        // "AT" framed by 16 ticks of silence.
        clearLogs();
        tick = 1'b1;
        applyStimulus("AT");
        waitCycles(40);
        checkLog("t1_log", "OK");
        checkOutput("t1_gapLatency", 32'(firstTxEdge - lastPopEdge), 32'd17);
        checkOutput("t1_consecutive", 32'(txGaps), 32'd0);
        checkOutput("t1_okCount", 32'(okCount), 32'd1);
        checkOutput("t1_okByte", 32'(okByte), 32'h4B);
        checkOutput("t1_errCount", 32'(errCount), 32'd0);
        checkOutput("t1_baud", 32'(baud_sel), 32'd4);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        // "AT+BAUD8" back-to-back, framed by a full buffer.
        tick = 1'b0;
        clearLogs();
        applyStimulus("AT+BAUD8");
        waitCycles(30);
        checkLog("t2_log", "OK115200");
        checkOutput("t2_latency", 32'(firstTxEdge - lastPopEdge), 32'd2);
        checkOutput("t2_consecutive", 32'(txGaps), 32'd0);
        checkOutput("t2_okCount", 32'(okCount), 32'd1);
        checkOutput("t2_baudAtLastPush", 32'(baudAtOk), 32'd4);
        checkOutput("t2_baudAfter", 32'(baud_sel), 32'd8);

        // Invalid digit.
        clearLogs();
        applyStimulus("AT+BAUD9");
        waitCycles(30);
        checkOutput("t3_errCount", 32'(errCount), 32'd1);
        checkOutput("t3_txCount", 32'(txLog.size()), 32'd0);
        checkOutput("t3_okCount", 32'(okCount), 32'd0);
        checkOutput("t3_baud", 32'(baud_sel), 32'd8);

        // Lowercase "at" framed by the gap timeout.
        clearLogs();
        tick = 1'b1;
        applyStimulus("at");
        waitCycles(40);
        checkOutput("t3b_errCount", 32'(errCount), 32'd1);
        checkOutput("t3b_txCount", 32'(txLog.size()), 32'd0);
        checkOutput("t3b_baud", 32'(baud_sel), 32'd8);

        // Reset after three bytes of the BAUD7 reply.
        tick = 1'b0;
        clearLogs();
        applyStimulus("AT+BAUD7");
        waitTxCount(3, "t4_tx3");
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t4_rst_tx_wr", 32'(tx_wr), 32'd0);
        checkOutput("t4_rst_busy", 32'(busy), 32'd0);
        checkOutput("t4_rst_cmd_ok", 32'(cmd_ok), 32'd0);
        checkOutput("t4_rst_baud", 32'(baud_sel), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        waitCycles(30);
        checkLog("t4_log", "OK5");
        checkOutput("t4_okCount", 32'(okCount), 32'd0);
        checkOutput("t4_baud", 32'(baud_sel), 32'd4);

        // "AT+BAUD4" with TX FIFO full for five cycles after the third push.
        clearLogs();
        applyStimulus("AT+BAUD4");
        waitTxCount(3, "t5_tx3");
        #1;
        tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tx_full = 1'b0;
        waitCycles(30);
        checkLog("t5_log", "OK9600");
        checkOutput("t5_stallCycles", 32'(stallCnt), 32'd5);
        checkOutput("t5_okCount", 32'(okCount), 32'd1);
        checkOutput("t5_baud", 32'(baud_sel), 32'd4);

        // Second "AT" arrives while the first reply is being sent.
        clearLogs();
        tick = 1'b1;
        applyStimulus("AT");
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (firstTxSeen) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("t6_firstTx_timeout", 32'd0, 32'd1);
        #1;
        applyStimulus("AT");
        waitCycles(60);
        checkLog("t6_log", "OKOK");
        checkOutput("t6_okCount", 32'(okCount), 32'd2);
        checkOutput("t6_rdDuringTx", 32'(rdDuringTx), 32'd0);
        checkOutput("t6_okRxqLen", 32'(okRxq.size()), 32'd2);
        if (okRxq.size() > 0) begin
            checkOutput("t6_rxHeldAtFirstOk", 32'(okRxq[0]), 32'd2);
        end
        checkOutput("t6_idle", 32'(busy), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
